call_return_ctrl: RTL and testbench
===================================

CALL_RETURN_CTRL -- requirements
Module: call_return_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 15, max live return entries (matches 8-bit x16 stack, usable depth 15).
REQ-002 SHALL have parameter RESET_PC, default 8'h00, PC value after reset.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-005 instr_valid  input  1  decode stage presents an op.
REQ-006 instr_ready  output  1  controller accepts op this cycle.
REQ-007 op  input  2  00 NEXT, 01 JMP, 10 CALL, 11 RET.
REQ-008 target  input  8  JMP/CALL destination.
REQ-009 pc  output  8  current program counter (registered).
REQ-010 stk_push  output  1  push request to stack.
REQ-011 stk_pop  output  1  pop request to stack.
REQ-012 stk_wdata  output  8  return address to stack data input.
REQ-013 stk_rdata  input  8  stack combinational top-of-stack.
REQ-014 stk_overflow / stk_underflow  input  1 each  stack registered error pulses.
REQ-015 depth  output  4  shadow count of live entries.
REQ-016 fault  output  1  sticky error; fault_code output 2: 01 overflow, 10 underflow, 11 stack/shadow mismatch.

Function
REQ-017 FSM states SHALL be RUN, PUSH, POP, CHK, FAULT; instr_ready=1 only in RUN.
REQ-018 Op accepted on edge where instr_valid && instr_ready; op/target latched at accept.
REQ-019 NEXT: pc<=pc+1 mod 256, stay RUN; latency 1 cycle.
REQ-020 JMP: pc<=target, stay RUN; latency 1 cycle.
REQ-021 CALL with depth<STACK_DEPTH: latch ret=pc+1 mod 256, go PUSH; PUSH drives stk_push=1, stk_wdata=ret for exactly one cycle, then pc<=target, depth+1, go CHK.
REQ-022 RET with depth>0: go POP; POP drives stk_pop=1 one cycle, pc<=stk_rdata at same edge, depth-1, go CHK.
REQ-023 CHK: if stk_overflow or stk_underflow =1 -> FAULT, fault_code=11; else -> RUN; CALL/RET total latency 3 cycles.
REQ-024 CALL with depth==STACK_DEPTH: no push, pc unchanged, -> FAULT, fault_code=01.
REQ-025 RET with depth==0: no pop, pc unchanged, -> FAULT, fault_code=10.
REQ-026 stk_push and stk_pop SHALL never be 1 in the same cycle; both 0 outside PUSH/POP.
REQ-027 FAULT is absorbing until reset: instr_ready=0, pc/depth frozen, no stack requests.
REQ-028 stk_wdata SHALL hold the latched return address in all states (0 after reset).

Reset
REQ-029 On reset: state RUN, pc=RESET_PC, depth=0, fault=0, fault_code=00, stk_push=0, stk_pop=0, stk_wdata=0.
REQ-030 Reset mid-CALL/RET SHALL abort immediately; stack and controller both return to empty, no partial push/pop counted.

Structure
REQ-031 Shared package cpu_pkg SHALL hold op encodings, FSM state enum, fault code constants, STACK_DEPTH default.
REQ-032 No sub-module; controller is single flat FSM + datapath, instantiated beside the stack in the CPU top.

Verification
REQ-033 Reset, NEXT x3 -> pc 00,01,02,03; depth 0; fault 0.
REQ-034 pc=8'h10, CALL target 8'h40 -> PUSH cycle stk_push=1 stk_wdata=8'h11; pc=8'h40, depth=1; RET -> stk_pop=1, pc=8'h11, depth=0.
REQ-035 pc=8'hFF, CALL target 8'h20 then RET -> pushed 8'h00, pc returns 8'h00 (wrap).
REQ-036 15 nested CALLs then 16th CALL -> depth=15, no push on 16th, fault=1 code 01, instr_ready=0.
REQ-037 RET at depth 0 -> no stk_pop, fault=1 code 10, pc unchanged.
REQ-038 Inject stk_underflow=1 in CHK after valid RET -> fault code 11; assert reset during PUSH -> pc=RESET_PC, depth=0, no fault.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: op encodings, controller FSM states, fault codes and
// default sizes used by the call/return controller and its neighbours.
package cpu_pkg;

  localparam int unsigned PC_W              = 8;
  localparam int unsigned DEPTH_W           = 4;
  localparam int unsigned STACK_DEPTH_DEF   = 15;

  typedef enum logic [1:0] {
    OP_NEXT = 2'b00,
    OP_JMP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_PUSH  = 3'd1,
    ST_POP   = 3'd2,
    ST_CHK   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_OVERFLOW = 2'b01;
  localparam logic [1:0] FC_UNDERFLW = 2'b10;
  localparam logic [1:0] FC_MISMATCH = 2'b11;

endpackage

// File: rtl/call_return_ctrl.sv
// Program-counter sequencer for NEXT/JMP/CALL/RET that drives an external
// return-address stack and tracks a shadow depth to detect stack errors.
module call_return_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [PC_W-1:0]   RESET_PC    = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [1:0]         op,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    pc,
  output logic               stk_push,
  output logic               stk_pop,
  output logic [PC_W-1:0]    stk_wdata,
  input  logic [PC_W-1:0]    stk_rdata,
  input  logic               stk_overflow,
  input  logic               stk_underflow,
  output logic [DEPTH_W-1:0] depth,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    ret_q, ret_d;
  logic [PC_W-1:0]    tgt_q, tgt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [1:0]         code_q, code_d;
  logic               ready_q, push_q, pop_q, fault_q;
  logic               accept;

  assign accept = instr_valid && ready_q;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    tgt_d   = tgt_q;
    depth_d = depth_q;
    code_d  = code_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (op_e'(op))
            OP_NEXT: pc_d = pc_q + PC_W'(1);
            OP_JMP:  pc_d = target;
            OP_CALL: begin
              if (depth_q == DEPTH_FULL) begin
                state_d = ST_FAULT;
                code_d  = FC_OVERFLOW;
              end else begin
                ret_d   = pc_q + PC_W'(1);
                tgt_d   = target;
                state_d = ST_PUSH;
              end
            end
            OP_RET: begin
              if (depth_q == DEPTH_W'(0)) begin
                state_d = ST_FAULT;
                code_d  = FC_UNDERFLW;
              end else begin
                state_d = ST_POP;
              end
            end
            default: state_d = ST_RUN;
          endcase
        end
      end
      ST_PUSH: begin
        pc_d    = tgt_q;
        depth_d = depth_q + DEPTH_W'(1);
        state_d = ST_CHK;
      end
      ST_POP: begin
        pc_d    = stk_rdata;
        depth_d = depth_q - DEPTH_W'(1);
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (stk_overflow || stk_underflow) begin
          state_d = ST_FAULT;
          code_d  = FC_MISMATCH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // Registered state; handshake/stack strobes follow the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      ret_q   <= '0;
      tgt_q   <= '0;
      depth_q <= '0;
      code_q  <= FC_NONE;
      ready_q <= 1'b1;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      tgt_q   <= tgt_d;
      depth_q <= depth_d;
      code_q  <= code_d;
      ready_q <= (state_d == ST_RUN);
      push_q  <= (state_d == ST_PUSH);
      pop_q   <= (state_d == ST_POP);
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign instr_ready = ready_q;
  assign pc          = pc_q;
  assign stk_push    = push_q;
  assign stk_pop     = pop_q;
  assign stk_wdata   = ret_q;
  assign depth       = depth_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural 16-entry stack model.
module tb_call_return_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] op;
  logic [7:0] target;
  logic [7:0] pc;
  logic       stk_push, stk_pop;
  logic [7:0] stk_wdata, stk_rdata;
  logic       stk_overflow, stk_underflow;
  logic [3:0] depth;
  logic       fault;
  logic [1:0] fault_code;

  logic [7:0] mem [16];
  logic [4:0] cnt;
  logic       m_ovf, m_udf, inj_udf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  call_return_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .target(target), .pc(pc), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_overflow(stk_overflow),
    .stk_underflow(stk_underflow), .depth(depth), .fault(fault), .fault_code(fault_code)
  );

  // Stack model: 16 entries, 15 usable, registered error pulses
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      m_ovf <= 1'b0;
      m_udf <= 1'b0;
    end else begin
      m_ovf <= stk_push && (cnt == 5'd15);
      m_udf <= stk_pop && (cnt == 5'd0);
      if (stk_push && cnt != 5'd15) begin
        mem[cnt[3:0]] <= stk_wdata;
        cnt <= cnt + 5'd1;
      end else if (stk_pop && cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
    end
  end

  assign stk_rdata     = (cnt == 5'd0) ? 8'h00 : mem[4'(cnt - 5'd1)];
  assign stk_overflow  = m_ovf;
  assign stk_underflow = m_udf | inj_udf;

  typedef struct {
    logic [1:0] op;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic [3:0] dep;
    logic       flt;
    logic [1:0] code;
    int         npush;
    int         npop;
    logic [7:0] wd;
    int         lat;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    #3;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issue one op and follow it until the controller is ready again or faulted
  task automatic do_op(input logic [1:0] o, input logic [7:0] t,
                       output int npush, output int npop,
                       output logic [7:0] wd, output int lat);
    int w;
    npush = 0; npop = 0; wd = 8'h00; lat = 0;
    w = 0;
    while (!instr_ready && w < 10) begin
      @(posedge clk); #1; w++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    instr_valid = 1'b1;
    op          = o;
    target      = t;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    w = 0;
    while (!instr_ready && !fault && w < 10) begin
      chk("push_pop_excl", int'(stk_push && stk_pop), 0);
      if (stk_push) begin npush++; wd = stk_wdata; end
      if (stk_pop) npop++;
      lat++;
      @(posedge clk); #1; w++;
    end
    if (!instr_ready && !fault) chk("op_timeout", 0, 1);
  endtask

  initial begin
    int np, npp, lt;
    logic [7:0] wd;
    inj_udf = 1'b0;
    op      = 2'b00;
    target  = 8'h00;

    vt[0]  = '{2'b00, 8'h00, 8'h01, 4'd0, 1'b0, 2'b00, 0, 0, 8'h00, 0};
    vt[1]  = '{2'b00, 8'h00, 8'h02, 4'd0, 1'b0, 2'b00, 0, 0, 8'h00, 0};
    vt[2]  = '{2'b00, 8'h00, 8'h03, 4'd0, 1'b0, 2'b00, 0, 0, 8'h00, 0};
    vt[3]  = '{2'b01, 8'h10, 8'h10, 4'd0, 1'b0, 2'b00, 0, 0, 8'h00, 0};
    vt[4]  = '{2'b10, 8'h40, 8'h40, 4'd1, 1'b0, 2'b00, 1, 0, 8'h11, 2};
    vt[5]  = '{2'b00, 8'h00, 8'h41, 4'd1, 1'b0, 2'b00, 0, 0, 8'h00, 0};
    vt[6]  = '{2'b11, 8'h00, 8'h11, 4'd0, 1'b0, 2'b00, 0, 1, 8'h00, 2};
    vt[7]  = '{2'b01, 8'hFF, 8'hFF, 4'd0, 1'b0, 2'b00, 0, 0, 8'h00, 0};
    vt[8]  = '{2'b10, 8'h20, 8'h20, 4'd1, 1'b0, 2'b00, 1, 0, 8'h00, 2};
    vt[9]  = '{2'b11, 8'h00, 8'h00, 4'd0, 1'b0, 2'b00, 0, 1, 8'h00, 2};
    vt[10] = '{2'b00, 8'h00, 8'h01, 4'd0, 1'b0, 2'b00, 0, 0, 8'h00, 0};
    vt[11] = '{2'b11, 8'h00, 8'h01, 4'd0, 1'b1, 2'b10, 0, 0, 8'h00, 0};

    do_reset();
    chk("rst_pc", pc, 8'h00);
    chk("rst_depth", depth, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_push_pop", {stk_push, stk_pop}, 0);
    chk("rst_wdata", stk_wdata, 8'h00);

    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].op, vt[i].tgt, np, npp, wd, lt);
      chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
      chk($sformatf("v%0d_depth", i), depth, vt[i].dep);
      chk($sformatf("v%0d_fault", i), fault, vt[i].flt);
      chk($sformatf("v%0d_code", i), fault_code, vt[i].code);
      chk($sformatf("v%0d_npush", i), np, vt[i].npush);
      chk($sformatf("v%0d_npop", i), npp, vt[i].npop);
      chk($sformatf("v%0d_lat", i), lt, vt[i].lat);
      if (vt[i].npush > 0) chk($sformatf("v%0d_wdata", i), wd, vt[i].wd);
    end

    // Fault is absorbing: offered ops are ignored
    instr_valid = 1'b1;
    op          = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abs_pc", pc, 8'h01);
      chk("abs_ready", instr_ready, 0);
      chk("abs_strobes", {stk_push, stk_pop}, 0);
    end
    instr_valid = 1'b0;

    // Fill to 15 nested calls, 16th must fault with overflow
    do_reset();
    for (int i = 0; i < 15; i++) begin
      do_op(2'b10, 8'(8'h50 + i), np, npp, wd, lt);
      chk($sformatf("nest%0d_depth", i), depth, i + 1);
      chk($sformatf("nest%0d_push", i), np, 1);
    end
    do_op(2'b10, 8'hAA, np, npp, wd, lt);
    chk("ovf_npush", np, 0);
    chk("ovf_depth", depth, 15);
    chk("ovf_fault", fault, 1);
    chk("ovf_code", fault_code, 2'b01);
    chk("ovf_ready", instr_ready, 0);
    chk("ovf_pc", pc, 8'h5E);

    // Underflow injected in CHK after a legal RET -> mismatch fault
    do_reset();
    do_op(2'b10, 8'h30, np, npp, wd, lt);
    chk("inj_call_pc", pc, 8'h30);
    instr_valid = 1'b1;
    op          = 2'b11;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    chk("inj_pop", stk_pop, 1);
    @(posedge clk);
    #1 inj_udf = 1'b1;
    @(posedge clk);
    #1 inj_udf = 1'b0;
    chk("inj_fault", fault, 1);
    chk("inj_code", fault_code, 2'b11);
    chk("inj_pc", pc, 8'h01);
    chk("inj_depth", depth, 0);

    // Reset asserted during PUSH aborts the call
    do_reset();
    instr_valid = 1'b1;
    op          = 2'b10;
    target      = 8'h77;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    chk("abort_in_push", stk_push, 1);
    reset = 1'b1;
    #1;
    chk("abort_pc", pc, 8'h00);
    chk("abort_depth", depth, 0);
    chk("abort_push", stk_push, 0);
    chk("abort_fault", fault, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_stack_cnt", cnt, 0);
    chk("abort_ready", instr_ready, 1);
    do_op(2'b00, 8'h00, np, npp, wd, lt);
    chk("abort_next_pc", pc, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
